// File: rtl/aclock_load_ctrl.sv
// aclock_load_ctrl: configuration sequencer for the aclock alarm-clock core.
// Arbitrates set-time / set-alarm requests from two requesters (round-robin),
// range-checks binary hour/minute, drives BCD digits plus a one-cycle load
// strobe to the core, and confirms time loads by readback with timeout/retry.
//
// Ports:
//   clk, reset                       clock (rising edge), async active-low reset
//   req{0,1}_valid/_kind/_hour/_min  request in (kind 0 = time, 1 = alarm)
//   req{0,1}_ready                   combinational accept, IDLE + granted only
//   done, err, resp_src              one-cycle completion / failure pulse + source
//   H_in1, H_in0, M_in1, M_in0       BCD digits to core
//   LD_time, LD_alarm                one-cycle load strobes to core
//   H_out1, H_out0, M_out1, M_out0   core time readback
module aclock_load_ctrl #(
    parameter int unsigned VERIFY_TIMEOUT = 8,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_kind,
    input  logic [4:0] req0_hour,
    input  logic [5:0] req0_min,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_kind,
    input  logic [4:0] req1_hour,
    input  logic [5:0] req1_min,
    output logic       done,
    output logic       err,
    output logic       resp_src,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    input  logic [1:0] H_out1,
    input  logic [3:0] H_out0,
    input  logic [3:0] M_out1,
    input  logic [3:0] M_out0
);

    localparam int unsigned TW = 8;
    localparam int unsigned RW = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        LOAD   = 3'd2,
        VERIFY = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t          state;
    logic            last_gnt;
    logic            cur_src;
    logic            cur_kind;
    logic [TW-1:0]   to_cnt;
    logic [RW-1:0]   retry_cnt;

    logic            gnt;
    logic            any_valid;
    logic            sel_kind;
    logic [4:0]      sel_hour;
    logic [5:0]      sel_min;
    logic            range_ok;
    logic            readback_match;

    // Round-robin grant: on a tie the requester not granted last wins.
    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt = ~last_gnt;
        end else if (req1_valid) begin
            gnt = 1'b1;
        end
    end

    assign any_valid  = req0_valid | req1_valid;
    assign req0_ready = (state == IDLE) && req0_valid && !gnt;
    assign req1_ready = (state == IDLE) && req1_valid && gnt;

    assign sel_kind = gnt ? req1_kind : req0_kind;
    assign sel_hour = gnt ? req1_hour : req0_hour;
    assign sel_min  = gnt ? req1_min  : req0_min;
    assign range_ok = (sel_hour <= 5'd23) && (sel_min <= 6'd59);

    assign readback_match = (H_out1 == H_in1) && (H_out0 == H_in0) &&
                            (M_out1 == M_in1) && (M_out0 == M_in0);

    // Sequencer: outputs are registered on the transition into the state that owns them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            cur_src   <= 1'b0;
            cur_kind  <= 1'b0;
            to_cnt    <= '0;
            retry_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            resp_src  <= 1'b0;
            H_in1     <= '0;
            H_in0     <= '0;
            M_in1     <= '0;
            M_in0     <= '0;
            LD_time   <= 1'b0;
            LD_alarm  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        last_gnt <= gnt;
                        cur_src  <= gnt;
                        cur_kind <= sel_kind;
                        if (range_ok) begin
                            H_in1 <= 2'(sel_hour / 5'd10);
                            H_in0 <= 4'(sel_hour % 5'd10);
                            M_in1 <= 4'(sel_min / 6'd10);
                            M_in0 <= 4'(sel_min % 6'd10);
                            state <= DRIVE;
                        end else begin
                            // Out-of-range: digits untouched, straight to error response.
                            err      <= 1'b1;
                            resp_src <= gnt;
                            state    <= RESP;
                        end
                    end
                end
                DRIVE: begin
                    LD_time  <= ~cur_kind;
                    LD_alarm <= cur_kind;
                    state    <= LOAD;
                end
                LOAD: begin
                    LD_time  <= 1'b0;
                    LD_alarm <= 1'b0;
                    if (cur_kind) begin
                        done     <= 1'b1;
                        resp_src <= cur_src;
                        state    <= RESP;
                    end else begin
                        to_cnt <= '0;
                        state  <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (readback_match) begin
                        done     <= 1'b1;
                        resp_src <= cur_src;
                        state    <= RESP;
                    end else if (to_cnt == TW'(VERIFY_TIMEOUT - 1)) begin
                        to_cnt <= '0;
                        if (retry_cnt < RW'(MAX_RETRY)) begin
                            // Digits are still held, so DRIVE simply re-presents them.
                            retry_cnt <= retry_cnt + RW'(1);
                            state     <= DRIVE;
                        end else begin
                            err      <= 1'b1;
                            resp_src <= cur_src;
                            state    <= RESP;
                        end
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                RESP: begin
                    done      <= 1'b0;
                    err       <= 1'b0;
                    retry_cnt <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aclock_load_ctrl.sv
// Self-checking bench for aclock_load_ctrl: directed requests, expected
// responses queued at accept and checked by an independent response monitor.
module tb_aclock_load_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_kind;
    logic [4:0] req0_hour;
    logic [5:0] req0_min;
    logic       req1_valid, req1_ready, req1_kind;
    logic [4:0] req1_hour;
    logic [5:0] req1_min;
    logic       done, err, resp_src;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0;

    aclock_load_ctrl #(.VERIFY_TIMEOUT(8), .MAX_RETRY(2)) dut (
        .clk(clk), .reset(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_kind(req0_kind),
        .req0_hour(req0_hour), .req0_min(req0_min),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_kind(req1_kind),
        .req1_hour(req1_hour), .req1_min(req1_min),
        .done(done), .err(err), .resp_src(resp_src),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        bit src;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   order_q[$];
    int   ld_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Simple core model: latches digits on LD_time; readback can be forced to 00:00.
    logic [13:0] core_time = '0;
    logic        force_zero = 1'b0;
    always @(posedge clk) if (LD_time) core_time <= {H_in1, H_in0, M_in1, M_in0};
    assign {H_out1, H_out0, M_out1, M_out0} = force_zero ? 14'd0 : core_time;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [13:0] dig(input int h1, input int h0, input int m1, input int m0);
        return {2'(h1), 4'(h0), 4'(m1), 4'(m0)};
    endfunction

    function automatic logic rdy(input int idx);
        return (idx == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every done/err pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done || err) begin
                chk("done_err_exclusive", 32'(done && err), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: done=%0b err=%0b with nothing pending (cycle %0d)",
                             done, err, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_err", 32'(err), 32'(e.is_err));
                    chk("resp_done", 32'(done), 32'(!e.is_err));
                    chk("resp_src", 32'(resp_src), 32'(e.src));
                    chk("resp_cycle", 32'(cyc), 32'(e.at));
                end
            end
            if (LD_time) ld_q.push_back(cyc);
        end
    end

    task automatic set_req(input int idx, input bit v, input bit kind, input int hr, input int mn);
        if (idx == 0) begin
            req0_valid = v; req0_kind = kind; req0_hour = 5'(hr); req0_min = 6'(mn);
        end else begin
            req1_valid = v; req1_kind = kind; req1_hour = 5'(hr); req1_min = 6'(mn);
        end
    endtask

    // Issue one request, queue its expected response, check digit/strobe timing.
    task automatic run_req(input int idx, input bit kind, input int hr, input int mn,
                           input bit exp_err, input int lat, input logic [13:0] exp_dig,
                           input bit strobe);
        int a0;
        int waited = 0;
        @(negedge clk);
        set_req(idx, 1'b1, kind, hr, mn);
        forever begin
            #1;
            if (rdy(idx) || waited >= 200) break;
            @(negedge clk);
            waited++;
        end
        if (!rdy(idx)) begin
            chk("accept_timeout", 32'(rdy(idx)), 1);
            set_req(idx, 1'b0, kind, hr, mn);
            return;
        end
        a0 = cyc;
        order_q.push_back(idx);
        exp_q.push_back('{exp_err, 1'(idx), a0 + lat});
        @(negedge clk);
        chk("ready_single_pulse", 32'(rdy(idx)), 0);
        set_req(idx, 1'b0, kind, hr, mn);
        chk("digits_c1", 32'({H_in1, H_in0, M_in1, M_in0}), 32'(exp_dig));
        chk("strobes_c1", 32'({LD_time, LD_alarm}), 0);
        if (strobe) begin
            @(negedge clk);
            chk("strobes_c2", 32'({LD_time, LD_alarm}), kind ? 32'd1 : 32'd2);
            @(negedge clk);
            chk("strobes_c3", 32'({LD_time, LD_alarm}), 0);
        end else begin
            @(negedge clk);
            chk("no_strobe", 32'({LD_time, LD_alarm}), 0);
            chk("digits_held", 32'({H_in1, H_in0, M_in1, M_in0}), 32'(exp_dig));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("resp_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 0, 0);
        set_req(1, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'({H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, done, err, resp_src}), 0);
        chk("rst_ready", 32'({req0_ready, req1_ready}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Time load with immediate readback match.
        ld_q.delete();
        run_req(0, 1'b0, 13, 47, 1'b0, 4, dig(1, 3, 4, 7), 1'b1);
        wait_idle();
        chk("time_ld_count", 32'(ld_q.size()), 1);

        // Alarm load: no verify, LD_time never rises.
        ld_q.delete();
        run_req(1, 1'b1, 7, 5, 1'b0, 3, dig(0, 7, 0, 5), 1'b1);
        wait_idle();
        chk("alarm_no_ld_time", 32'(ld_q.size()), 0);

        // Tie after req1 was last granted: req0 first.
        order_q.delete();
        fork
            run_req(0, 1'b0, 10, 0, 1'b0, 4, dig(1, 0, 0, 0), 1'b1);
            run_req(1, 1'b0, 11, 11, 1'b0, 4, dig(1, 1, 1, 1), 1'b1);
        join
        wait_idle();
        chk("tie1_first", 32'(order_q[0]), 0);
        chk("tie1_second", 32'(order_q[1]), 1);

        // Range errors: digits stay at 11:11, no strobe.
        run_req(0, 1'b0, 24, 0, 1'b1, 1, dig(1, 1, 1, 1), 1'b0);
        wait_idle();
        run_req(0, 1'b1, 5, 60, 1'b1, 1, dig(1, 1, 1, 1), 1'b0);
        wait_idle();

        // Tie after req0 was last granted: req1 first.
        order_q.delete();
        fork
            run_req(0, 1'b0, 8, 15, 1'b0, 4, dig(0, 8, 1, 5), 1'b1);
            run_req(1, 1'b1, 19, 45, 1'b0, 3, dig(1, 9, 4, 5), 1'b1);
        join
        wait_idle();
        chk("tie2_first", 32'(order_q[0]), 1);
        chk("tie2_second", 32'(order_q[1]), 0);

        // Readback stuck at 00:00: three loads 10 cycles apart, then err at cycle 31.
        force_zero = 1'b1;
        ld_q.delete();
        run_req(0, 1'b0, 9, 30, 1'b1, 31, dig(0, 9, 3, 0), 1'b1);
        wait_idle();
        force_zero = 1'b0;
        chk("retry_ld_count", 32'(ld_q.size()), 3);
        if (ld_q.size() == 3) begin
            chk("retry_gap1", 32'(ld_q[1] - ld_q[0]), 10);
            chk("retry_gap2", 32'(ld_q[2] - ld_q[1]), 10);
        end
        run_req(1, 1'b1, 23, 59, 1'b0, 3, dig(2, 3, 5, 9), 1'b1);
        wait_idle();

        // Reset in VERIFY: everything clears at once, no response afterwards.
        force_zero = 1'b1;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 12, 34);
        #1;
        chk("rstv_accept", 32'(req0_ready), 1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 12, 34);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstv_outputs", 32'({H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, done, err, resp_src}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        force_zero = 1'b0;
        repeat (12) @(negedge clk);

        // Pointer back to 1 after reset: req0 wins the tie.
        order_q.delete();
        fork
            run_req(0, 1'b1, 1, 2, 1'b0, 3, dig(0, 1, 0, 2), 1'b1);
            run_req(1, 1'b1, 3, 4, 1'b0, 3, dig(0, 3, 0, 4), 1'b1);
        join
        wait_idle();
        chk("tie3_first", 32'(order_q[0]), 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
